bp_be_stride_detector: RTL and testbench

Trains a small PC-indexed reference table on committed integer loads and detects constant-stride streams. Once a stream is confident, it emits one prefetch request: PC, effective address, stride and prefetch count. The request goes through a one-entry valid/ready buffer. Sits in the BE checker directly upstream of `bp_be_prefetch_generator` and drives its striding-load interface.

---
 rtl/bp_be_pkg.sv | 29 ++
 rtl/bp_be_stride_table.sv | 101 ++++++++++
 rtl/bp_be_stride_detector.sv | 96 +++++++++
 tb/tb_bp_be_stride_detector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the BE stride detector and its glue to the prefetch generator.
// The struct field widths are these defaults; the modules' width parameters must keep them.
package bp_be_pkg;

    localparam int unsigned vaddr_width_gp  = 39;
    localparam int unsigned dpath_width_gp  = 64;
    localparam int unsigned tag_width_gp    = 10;
    localparam int unsigned stride_width_gp = 8;
    localparam int unsigned loop_range_gp   = 8;
    localparam int unsigned conf_max_gp     = 3;
    localparam int unsigned conf_width_gp   = $clog2(conf_max_gp + 1);

    typedef struct packed {
        logic                              v;
        logic [tag_width_gp-1:0]           tag;
        logic [dpath_width_gp-1:0]         last_addr;
        logic signed [stride_width_gp-1:0] stride;
        logic [conf_width_gp-1:0]          conf;
        logic [loop_range_gp-1:0]          remain;
    } bp_be_stride_entry_s;

    typedef struct packed {
        logic [vaddr_width_gp-1:0]  pc;
        logic [dpath_width_gp-1:0]  eff_addr;
        logic [stride_width_gp-1:0] stride;
        logic [loop_range_gp-1:0]   loop_counter;
    } bp_be_stride_req_s;

endpackage

// File: rtl/bp_be_stride_table.sv
// Direct-mapped PC-indexed stride table: combinational read, update on the commit edge,
// plus the match / confidence / trigger decision for the committing load.
module bp_be_stride_table
    import bp_be_pkg::*;
#(
    parameter int unsigned entries_p      = 8,
    parameter int unsigned tag_width_p    = tag_width_gp,
    parameter int unsigned stride_width_p = stride_width_gp,
    parameter int unsigned loop_range_p   = loop_range_gp,
    parameter int unsigned conf_max_p     = conf_max_gp,
    parameter int unsigned vaddr_width_p  = vaddr_width_gp,
    parameter int unsigned dpath_width_p  = dpath_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [dpath_width_p-1:0]  commit_eff_addr_i,
    input  logic [loop_range_p-1:0]   degree_i,
    output logic                      trigger_o,
    output logic [stride_width_p-1:0] stride_o
);

    localparam int unsigned idx_width_lp  = $clog2(entries_p);
    localparam int unsigned conf_width_lp = $clog2(conf_max_p + 1);
    localparam logic [conf_width_lp-1:0] conf_max_lp = conf_width_lp'(conf_max_p);

    bp_be_stride_entry_s tbl_q [entries_p];
    bp_be_stride_entry_s tbl_d [entries_p];

    logic [idx_width_lp-1:0]  idx;
    logic [tag_width_p-1:0]   tag;
    bp_be_stride_entry_s      rd, wr;
    logic [dpath_width_p-1:0] delta;
    logic [dpath_width_p-stride_width_p:0] delta_hi;
    logic                     hit, usable, match, fire;
    logic [conf_width_lp-1:0] conf_inc;

    assign idx      = commit_pc_i[2 +: idx_width_lp];
    assign tag      = commit_pc_i[2+idx_width_lp +: tag_width_p];
    // Upper bits including the stride sign bit must all agree to fit a signed stride.
    assign delta_hi = delta[dpath_width_p-1:stride_width_p-1];

    always_comb begin
        rd       = tbl_q[idx];
        hit      = rd.v && (rd.tag == tag);
        delta    = commit_eff_addr_i - rd.last_addr;
        usable   = (delta != '0) && ((&delta_hi) || ~(|delta_hi));
        match    = hit && usable && (delta[stride_width_p-1:0] == rd.stride);
        conf_inc = (rd.conf == conf_max_lp) ? conf_max_lp : rd.conf + conf_width_lp'(1);
        fire     = 1'b0;

        wr           = rd;
        wr.last_addr = commit_eff_addr_i;
        if (!hit) begin
            wr           = '0;
            wr.v         = 1'b1;
            wr.tag       = tag;
            wr.last_addr = commit_eff_addr_i;
        end else if (match) begin
            wr.conf = conf_inc;
            if (conf_inc == conf_max_lp) begin
                if (rd.remain == '0) begin
                    if (degree_i != '0) begin
                        fire      = 1'b1;
                        wr.remain = degree_i - loop_range_p'(1);
                    end
                end else begin
                    wr.remain = rd.remain - loop_range_p'(1);
                end
            end
        end else if (usable) begin
            wr.stride = delta[stride_width_p-1:0];
            wr.conf   = '0;
            wr.remain = '0;
        end else begin
            wr.stride = '0;
            wr.conf   = '0;
            wr.remain = '0;
        end

        tbl_d = tbl_q;
        if (commit_v_i) begin
            tbl_d[idx] = wr;
        end
    end

    assign trigger_o = commit_v_i && fire;
    assign stride_o  = rd.stride;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(entries_p); i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Stride detector top: trains the stride table on committed loads and holds the resulting
// prefetch request in a one-entry valid/ready buffer, counting triggers lost to a full buffer.
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter int unsigned entries_p      = 8,
    parameter int unsigned tag_width_p    = tag_width_gp,
    parameter int unsigned stride_width_p = stride_width_gp,
    parameter int unsigned loop_range_p   = loop_range_gp,
    parameter int unsigned conf_max_p     = conf_max_gp,
    parameter int unsigned vaddr_width_p  = vaddr_width_gp,
    parameter int unsigned dpath_width_p  = dpath_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [dpath_width_p-1:0]  commit_eff_addr_i,
    input  logic [loop_range_p-1:0]   degree_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [dpath_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic [15:0]               drop_count_o
);

    logic                      trigger;
    logic [stride_width_p-1:0] trig_stride;
    logic                      pop;

    bp_be_stride_req_s req_q, req_d;
    logic              v_q, v_d;
    logic [15:0]       drop_q, drop_d;

    bp_be_stride_table #(
        .entries_p      (entries_p),
        .tag_width_p    (tag_width_p),
        .stride_width_p (stride_width_p),
        .loop_range_p   (loop_range_p),
        .conf_max_p     (conf_max_p),
        .vaddr_width_p  (vaddr_width_p),
        .dpath_width_p  (dpath_width_p)
    ) u_table (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_eff_addr_i (commit_eff_addr_i),
        .degree_i          (degree_i),
        .trigger_o         (trigger),
        .stride_o          (trig_stride)
    );

    assign pop = v_q & ready_and_i;

    always_comb begin
        v_d    = v_q;
        req_d  = req_q;
        drop_d = drop_q;
        if (trigger && (!v_q || pop)) begin
            v_d                = 1'b1;
            req_d.pc           = commit_pc_i;
            req_d.eff_addr     = commit_eff_addr_i;
            req_d.stride       = trig_stride;
            req_d.loop_counter = degree_i;
        end else if (trigger) begin
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (pop) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            req_q  <= '0;
            drop_q <= '0;
        end else begin
            v_q    <= v_d;
            req_q  <= req_d;
            drop_q <= drop_d;
        end
    end

    assign v_o            = v_q;
    assign pc_o           = req_q.pc;
    assign eff_addr_o     = req_q.eff_addr;
    assign stride_o       = req_q.stride;
    assign loop_counter_o = req_q.loop_counter;
    assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for bp_be_stride_detector: a behavioural table/buffer model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_bp_be_stride_detector;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        commit_v_i;
    logic [38:0] commit_pc_i;
    logic [63:0] commit_eff_addr_i;
    logic [7:0]  degree_i;
    logic        v_o;
    logic        ready_and_i;
    logic [38:0] pc_o;
    logic [63:0] eff_addr_o;
    logic [7:0]  stride_o;
    logic [7:0]  loop_counter_o;
    logic [15:0] drop_count_o;

    always #5 clk = ~clk;

    bp_be_stride_detector dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_eff_addr_i (commit_eff_addr_i),
        .degree_i          (degree_i),
        .v_o               (v_o),
        .ready_and_i       (ready_and_i),
        .pc_o              (pc_o),
        .eff_addr_o        (eff_addr_o),
        .stride_o          (stride_o),
        .loop_counter_o    (loop_counter_o),
        .drop_count_o      (drop_count_o)
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-index records and the expected request buffer.
    bit          m_v    [8];
    int          m_tag  [8];
    logic [63:0] m_last [8];
    int          m_str  [8];
    int          m_conf [8];
    int          m_rem  [8];
    bit          e_v    = 1'b0;
    logic [38:0] e_pc   = '0;
    logic [63:0] e_addr = '0;
    int          e_str  = 0;
    logic [7:0]  e_loop = '0;
    int          e_drop = 0;
    int          n_push = 0;

    always @(posedge clk) begin : model
        int     idx;
        int     tag;
        longint d;
        bit     trig;
        bit     pop;
        idx  = 0;
        trig = 1'b0;
        if (!reset_n_i) begin
            for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
            e_v = 1'b0; e_pc = '0; e_addr = '0; e_str = 0; e_loop = '0; e_drop = 0;
        end else begin
            pop = e_v && ready_and_i;
            if (commit_v_i) begin
                idx = int'((commit_pc_i >> 2) & 39'd7);
                tag = int'((commit_pc_i >> 5) & 39'd1023);
                if (!m_v[idx] || m_tag[idx] != tag) begin
                    m_v[idx] = 1'b1; m_tag[idx] = tag; m_last[idx] = commit_eff_addr_i;
                    m_str[idx] = 0; m_conf[idx] = 0; m_rem[idx] = 0;
                end else begin
                    d = longint'(commit_eff_addr_i - m_last[idx]);
                    if (d != 0 && d >= -128 && d <= 127) begin
                        if (d == longint'(m_str[idx])) begin
                            if (m_conf[idx] < 3) m_conf[idx]++;
                            if (m_conf[idx] == 3) begin
                                if (m_rem[idx] == 0) begin
                                    if (degree_i != 0) begin
                                        trig = 1'b1;
                                        m_rem[idx] = int'(degree_i) - 1;
                                    end
                                end else begin
                                    m_rem[idx]--;
                                end
                            end
                        end else begin
                            m_str[idx] = int'(d); m_conf[idx] = 0; m_rem[idx] = 0;
                        end
                    end else begin
                        m_str[idx] = 0; m_conf[idx] = 0; m_rem[idx] = 0;
                    end
                    m_last[idx] = commit_eff_addr_i;
                end
            end
            if (trig) begin
                if (!e_v || pop) begin
                    e_v = 1'b1; e_pc = commit_pc_i; e_addr = commit_eff_addr_i;
                    e_str = m_str[idx]; e_loop = degree_i; n_push++;
                end else if (e_drop < 65535) begin
                    e_drop++;
                end
            end else if (pop) begin
                e_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] es;
        if (run) begin
            es = e_str[7:0];
            chk("v_o", 64'(v_o), 64'(e_v));
            chk("drop_count_o", 64'(drop_count_o), 64'(e_drop));
            if (e_v) begin
                chk("pc_o", 64'(pc_o), 64'(e_pc));
                chk("eff_addr_o", eff_addr_o, e_addr);
                chk("stride_o", 64'(stride_o), 64'(es));
                chk("loop_counter_o", 64'(loop_counter_o), 64'(e_loop));
            end
        end
    end

    task automatic ld(input logic [38:0] pc, input logic [63:0] addr);
        commit_v_i        = 1'b1;
        commit_pc_i       = pc;
        commit_eff_addr_i = addr;
        @(negedge clk);
        commit_v_i = 1'b0;
    endtask

    localparam logic [38:0] PcA  = 39'h80001000;
    localparam logic [38:0] PcA2 = 39'h80001020;
    localparam logic [38:0] PcB  = 39'h80002004;
    localparam logic [38:0] PcC  = 39'h80003008;
    localparam logic [38:0] PcD  = 39'h8000400C;
    localparam logic [38:0] PcE  = 39'h80005010;

    initial begin
        reset_n_i = 1'b0; commit_v_i = 1'b0; commit_pc_i = '0; commit_eff_addr_i = '0;
        degree_i = 8'd4; ready_and_i = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b1;
        chk("reset v_o", 64'(v_o), 64'd0);
        chk("reset eff_addr", eff_addr_o, 64'd0);
        chk("reset drop", 64'(drop_count_o), 64'd0);
        reset_n_i = 1'b1;

        // Training: one request on the fifth load, the next on the ninth.
        for (int i = 0; i < 4; i++) ld(PcA, 64'h1000 + 64'(16 * i));
        chk("train no early req", 64'(n_push), 64'd0);
        ld(PcA, 64'h1040);
        chk("train v_o", 64'(v_o), 64'd1);
        chk("train pc", 64'(pc_o), 64'(PcA));
        chk("train eff_addr", eff_addr_o, 64'h1040);
        chk("train stride", 64'(stride_o), 64'h10);
        chk("train loop_counter", 64'(loop_counter_o), 64'd4);
        for (int i = 5; i < 8; i++) ld(PcA, 64'h1000 + 64'(16 * i));
        chk("loads 6-8 silent", 64'(n_push), 64'd1);
        ld(PcA, 64'h1080);
        chk("load 9 retrigger", 64'(n_push), 64'd2);
        chk("load 9 eff_addr", eff_addr_o, 64'h1080);

        // Negative stride.
        for (int i = 0; i < 5; i++) ld(PcB, 64'h2040 - 64'(8 * i));
        chk("neg stride", 64'(stride_o), 64'hF8);
        chk("neg eff_addr", eff_addr_o, 64'h2020);

        // Delta 0x100 does not fit an 8-bit stride.
        for (int i = 0; i < 8; i++) ld(PcC, 64'h3000 + 64'(256 * i));
        chk("overflow no req", 64'(n_push), 64'd3);

        // Aliasing: eviction forces full retraining.
        ld(PcA2, 64'h5000);
        for (int i = 0; i < 4; i++) ld(PcA, 64'h1090 + 64'(16 * i));
        chk("alias no early req", 64'(n_push), 64'd3);
        ld(PcA, 64'h10D0);
        chk("alias retrigger", 64'(n_push), 64'd4);
        chk("alias eff_addr", eff_addr_o, 64'h10D0);

        // Backpressure with degree 1: every saturated match triggers.
        @(negedge clk);
        degree_i = 8'd1; ready_and_i = 1'b0;
        for (int i = 0; i < 5; i++) ld(PcD, 64'h4000 + 64'(4 * i));
        chk("bp first req", eff_addr_o, 64'h4010);
        ld(PcD, 64'h4014);
        chk("bp drop", 64'(drop_count_o), 64'd1);
        chk("bp held", eff_addr_o, 64'h4010);
        ready_and_i = 1'b1;
        ld(PcD, 64'h4018);
        ready_and_i = 1'b0;
        chk("bp pop+push v_o", 64'(v_o), 64'd1);
        chk("bp pop+push eff_addr", eff_addr_o, 64'h4018);
        chk("bp pushes", 64'(n_push), 64'd6);

        // Reset mid-stream with a pending request.
        reset_n_i = 1'b0;
        @(negedge clk);
        chk("rst v_o", 64'(v_o), 64'd0);
        chk("rst pc", 64'(pc_o), 64'd0);
        chk("rst eff_addr", eff_addr_o, 64'd0);
        chk("rst stride", 64'(stride_o), 64'd0);
        chk("rst loop", 64'(loop_counter_o), 64'd0);
        chk("rst drop", 64'(drop_count_o), 64'd0);
        reset_n_i = 1'b1; ready_and_i = 1'b1; degree_i = 8'd4;
        for (int i = 0; i < 4; i++) ld(PcD, 64'h401C + 64'(4 * i));
        chk("post-rst no early req", 64'(n_push), 64'd6);
        ld(PcD, 64'h402C);
        chk("post-rst trigger", 64'(n_push), 64'd7);
        chk("post-rst eff_addr", eff_addr_o, 64'h402C);

        // Degree 0 never triggers.
        degree_i = 8'd0;
        for (int i = 0; i < 10; i++) ld(PcE, 64'h6000 + 64'(8 * i));
        chk("degree0 no req", 64'(n_push), 64'd7);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
